// File: rtl/ram_rd_arbiter.sv
// ram_rd_arbiter: shares the single read port of one RAM between NREQ
// requesters. One read is granted per cycle, round-robin. Each read is tagged
// with its requester index, and the tag travels down a fixed-latency pipe so
// the returning data is steered back to the requester that issued it.
module ram_rd_arbiter #(
    parameter int NREQ   = 2,
    parameter int AW     = 8,
    parameter int DW     = 256,
    parameter int RD_LAT = 2
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [DW-1:0]       rsp_data,
    output logic [AW-1:0]       rd_addr,
    output logic                rd_read,
    input  logic [DW-1:0]       rd_data,
    input  logic                rd_valid,
    output logic                err_sticky,
    input  logic                err_clr
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] winner;
    logic          found;

    // Tag pipe: stage 0 is loaded at the accept edge; the head stage lines up
    // with the rd_valid/rd_data the RAM presents in the same cycle.
    logic          tag_vld [RD_LAT];
    logic [IW-1:0] tag_idx [RD_LAT];
    logic          head_vld;
    logic [IW-1:0] head_idx;
    logic          orphan;
    logic          missing;

    assign head_vld = tag_vld[RD_LAT-1];
    assign head_idx = tag_idx[RD_LAT-1];

    // Round-robin search starting just after the last winner.
    always_comb begin : arb_search
        logic [IW-1:0] cand;
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned; a missing default here would infer a latch.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IW'((int'(rr_ptr) + off) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // One-hot grant and the winner's address; forced low while in reset.
    always_comb begin
        req_ready = '0;
        rd_addr   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = !areset && found && (winner == IW'(i));
            if (req_ready[i]) begin
                rd_addr = req_addr[i*AW +: AW];
            end
        end
    end

    assign rd_read = |(req_valid & req_ready);

    // Pointer moves to the winner only when a read is actually accepted.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_ptr <= LAST_IDX;
        end else if (rd_read) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values regardless of block order.
            rr_ptr <= winner;
        end
    end

    // Shift the tag pipe every cycle; a reset drops all reads in flight.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            // NOTE: this array is control state (valid bits), so unlike a data
            // memory it must be reset; stale tags would misroute responses.
            for (int s = 0; s < RD_LAT; s++) begin
                tag_vld[s] <= 1'b0;
                tag_idx[s] <= '0;
            end
        end else begin
            tag_vld[0] <= rd_read;
            tag_idx[0] <= winner;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_idx[s] <= tag_idx[s-1];
            end
        end
    end

    // Steer returning data to the requester named by the head tag.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = rd_valid && head_vld && (head_idx == IW'(i));
        end
    end

    assign rsp_data = rd_data;

    // Data without a tag, or a tag without data, is a protocol error.
    assign orphan  = rd_valid && !head_vld;
    assign missing = head_vld && !rd_valid;

    // Sticky error flag; a new error on the clear edge takes precedence.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_sticky <= 1'b0;
        end else if (orphan || missing) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Testbench for ram_rd_arbiter: a driver with a round-robin reference model
// pushes expected responses into a queue; a monitor pops and compares them.
module tb_ram_rd_arbiter;

    localparam int NREQ   = 2;
    localparam int AW     = 8;
    localparam int DW     = 256;
    localparam int RD_LAT = 2;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [AW-1:0]     rd_addr;
    logic              rd_read;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              err_sticky;
    logic              err_clr = 1'b0;

    // Second instance with four requesters for the fairness scenario.
    logic [3:0]        req_valid4 = '0;
    logic [4*AW-1:0]   req_addr4 = '0;
    logic [3:0]        req_ready4;
    logic [3:0]        rsp_valid4;
    logic [DW-1:0]     rsp_data4;
    logic [AW-1:0]     rd_addr4;
    logic              rd_read4;
    logic [DW-1:0]     rd_data4 = '0;
    logic              rd_valid4;
    logic              err_sticky4;
    logic [1:0]        echo4 = '0;

    // RAM model controls.
    logic ram_drop   = 1'b0;
    logic orphan_inj = 1'b0;
    bit       st_vld  [RD_LAT];
    bit [7:0] st_addr [RD_LAT];

    typedef struct {
        int           idx;
        logic [DW-1:0] data;
        int           due;
        bit           dropped;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last = NREQ - 1;
    int n_acc = 0;
    int n_exp = 0;
    int n_rsp = 0;

    ram_rd_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
        .aclk(aclk), .areset(areset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rd_addr(rd_addr), .rd_read(rd_read), .rd_data(rd_data), .rd_valid(rd_valid),
        .err_sticky(err_sticky), .err_clr(err_clr)
    );

    ram_rd_arbiter #(.NREQ(4), .AW(AW), .DW(DW), .RD_LAT(2)) u_dut4 (
        .aclk(aclk), .areset(areset), .req_valid(req_valid4), .req_addr(req_addr4),
        .req_ready(req_ready4), .rsp_valid(rsp_valid4), .rsp_data(rsp_data4),
        .rd_addr(rd_addr4), .rd_read(rd_read4), .rd_data(rd_data4), .rd_valid(rd_valid4),
        .err_sticky(err_sticky4), .err_clr(err_clr)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // RAM row r holds sixteen 16-bit words 0x0A00 + 16r + j.
    function automatic logic [DW-1:0] row_pat(input logic [7:0] r);
        logic [DW-1:0] p;
        for (int j = 0; j < 16; j++) begin
            p[j*16 +: 16] = 16'h0A00 + 16'(r) * 16'd16 + 16'(j);
        end
        return p;
    endfunction

    // Fixed-latency RAM; it keeps returning data across a reset of the arbiter.
    always @(posedge aclk) begin
        st_vld[0]  <= rd_read && !ram_drop;
        st_addr[0] <= rd_addr;
        for (int s = 1; s < RD_LAT; s++) begin
            st_vld[s]  <= st_vld[s-1];
            st_addr[s] <= st_addr[s-1];
        end
    end

    assign rd_valid = st_vld[RD_LAT-1] | orphan_inj;
    assign rd_data  = row_pat(st_addr[RD_LAT-1]);

    always @(posedge aclk) echo4 <= {echo4[0], rd_read4};
    assign rd_valid4 = echo4[1];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // One cycle of stimulus for the main instance plus the reference arbiter.
    task automatic step(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] a1,
                        input bit rst = 1'b0, input bit drop = 1'b0,
                        input bit orph = 1'b0, input bit clr = 1'b0);
        int w;
        logic [1:0] exp_rdy;
        logic [7:0] exp_addr;
        @(negedge aclk);
        areset     = rst;
        req_valid  = v;
        req_addr   = {a1, a0};
        ram_drop   = drop;
        orphan_inj = orph;
        err_clr    = clr;
        if (rst) begin
            last = NREQ - 1;
            exp_q.delete();
        end
        w = -1;
        if (!rst) begin
            for (int off = 1; off <= NREQ; off++) begin
                int c;
                c = (last + off) % NREQ;
                if (w < 0 && ((v >> c) & 2'b01) != 2'b00) w = c;
            end
        end
        exp_rdy  = (w >= 0) ? (2'b01 << w) : 2'b00;
        exp_addr = (w == 0) ? a0 : (w == 1) ? a1 : 8'h00;
        #1;
        check("req_ready", req_ready, exp_rdy);
        check("rd_read", rd_read, w >= 0);
        check("rd_addr", rd_addr, exp_addr);
        if (w >= 0) begin
            last = w;
            n_acc++;
            if (!drop) n_exp++;
            exp_q.push_back('{idx: w, data: row_pat(exp_addr), due: cyc + RD_LAT, dropped: drop});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 8'h00, 8'h00);
    endtask

    // Monitor: every cycle either the head expectation is due or nothing is.
    initial begin
        forever begin
            @(negedge aclk);
            #2;
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.dropped) begin
                    check("rsp_valid_dropped", rsp_valid, 2'b00);
                end else begin
                    check("rsp_valid", rsp_valid, 2'b01 << e.idx);
                    check("rsp_data", rsp_data, e.data);
                end
            end else begin
                check("rsp_idle", rsp_valid, 2'b00);
            end
            if (rsp_valid != 2'b00) n_rsp++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] fair_exp [5];
        int soak_acc0, soak_exp0, soak_rsp0;

        // Reset values with requests pending.
        step(2'b11, 8'h01, 8'h02, 1'b1);
        check("reset_err", err_sticky, 1'b0);
        check("reset_rsp", rsp_valid, 2'b00);
        idle(2);

        // Single read from requester 0.
        step(2'b01, 8'h05, 8'h00);
        idle(3);
        check("single_err", err_sticky, 1'b0);

        // Contention: both requesters valid for six cycles.
        for (int i = 0; i < 6; i++) step(2'b11, 8'(i), 8'(8'h10 + i));
        idle(3);
        check("contention_err", err_sticky, 1'b0);

        // Fairness on the four-requester instance: r3 first, then r2/r3.
        fair_exp[0] = 4'b0100; fair_exp[1] = 4'b1000; fair_exp[2] = 4'b0100;
        fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0100;
        @(negedge aclk);
        req_valid4 = 4'b1000;
        #1 check("fair_first", req_ready4, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            req_valid4 = 4'b1100;
            req_addr4  = {8'(8'h30 + i), 8'(8'h20 + i), 8'h00, 8'h00};
            #1 check("fair_grant", req_ready4, fair_exp[i]);
        end
        @(negedge aclk);
        req_valid4 = 4'b0000;

        // Orphan data, then a clean clear.
        idle(1);
        step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("orphan_err", err_sticky, 1'b1);
        step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("clear_err", err_sticky, 1'b0);

        // Orphan and clear on the same edge: the set wins.
        step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("set_wins", err_sticky, 1'b1);
        step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("clear_err2", err_sticky, 1'b0);

        // Missing data: the RAM drops one response.
        step(2'b01, 8'h33, 8'h00, 1'b0, 1'b1);
        idle(1);
        check("missing_early", err_sticky, 1'b0);
        idle(1);
        check("missing_early2", err_sticky, 1'b0);
        idle(1);
        check("missing_err", err_sticky, 1'b1);
        step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("clear_err3", err_sticky, 1'b0);

        // Reset mid-flight: two reads outstanding when reset hits.
        step(2'b01, 8'h20, 8'h00);
        step(2'b10, 8'h00, 8'h21);
        step(2'b11, 8'h00, 8'h00, 1'b1);
        check("midrst_rsp", rsp_valid, 2'b00);
        check("midrst_err", err_sticky, 1'b0);
        step(2'b11, 8'h40, 8'h41);
        idle(1);
        check("midrst_orphan_err", err_sticky, 1'b1);
        idle(3);
        step(2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("clear_err4", err_sticky, 1'b0);

        // Random soak: 500 accepted requests.
        soak_acc0 = n_acc;
        soak_exp0 = n_exp;
        soak_rsp0 = n_rsp;
        for (int i = 0; i < 4000 && (n_acc - soak_acc0) < 500; i++) begin
            step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
        idle(RD_LAT + 3);
        check("soak_requests", 32'(n_acc - soak_acc0), 32'd500);
        check("soak_rsp_count", 32'(n_rsp - soak_rsp0), 32'(n_exp - soak_exp0));
        check("soak_queue_empty", 32'(exp_q.size()), 32'd0);
        check("soak_err", err_sticky, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_rd_arbiter.md
Name: ram_rd_arbiter

Overview:
- Shares the single read port of one ram256x256-style RAM between NREQ requesters.
- Typical requesters: the credit_return descriptor/payload fetch path and a debug/scrub reader.
- Grants one read per cycle, round-robin, and drives rd_addr/rd_read to the RAM.
- Tracks each read in flight and routes the returning rd_valid/rd_data to the requester that issued it, with no reordering.

Parameters:
- NREQ, 2: number of requesters, 2..8.
- AW, 8: RAM read address width.
- DW, 256: RAM read data width.
- RD_LAT, 2: fixed cycles from rd_read sampled high to rd_valid high at the RAM, >=1.

Ports:
- aclk  in  1: clock, all logic on posedge.
- areset  in  1: asynchronous, active-high reset.
- req_valid  in  NREQ: read request per requester.
- req_addr  in  NREQ*AW: request address; requester i uses bits [i*AW +: AW].
- req_ready  out  NREQ: grant; a request is accepted on a posedge where req_valid[i] & req_ready[i].
- rsp_valid  out  NREQ: response strobe, one-hot or zero.
- rsp_data  out  DW: response data, equal to rd_data; valid only when rsp_valid != 0.
- rd_addr  out  AW: RAM read address.
- rd_read  out  1: RAM read strobe.
- rd_data  in  DW: RAM read data.
- rd_valid  in  1: RAM read data valid.
- err_sticky  out  1: protocol error seen since reset or last clear.
- err_clr  in  1: synchronous clear of err_sticky.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rd_read=0, rd_addr=0, err_sticky=0, rr_ptr=NREQ-1 (so requester 0 has first priority), tag pipe all invalid.
- Arbitration:
  - Combinational, same cycle.
  - Search order is rr_ptr+1, rr_ptr+2, … modulo NREQ; the first requester with req_valid set gets the grant.
  - req_ready is one-hot on the winner and zero when no requester is valid.
  - req_ready never asserts for a requester whose req_valid is low.
  - rd_read = |(req_valid & req_ready); rd_addr = winner's address, combinational.
  - On accept, rr_ptr <= winner index. With no accept, rr_ptr holds.
- Throughput: one accepted read per cycle sustained. No bubbles between grants.
- Tag pipe:
  - RD_LAT-deep shift register of {vld, idx[clog2(NREQ)-1:0]}, shifted every cycle.
  - Stage 0 loads {rd_read, winner}.
  - The head entry (stage RD_LAT-1) corresponds to the rd_valid/rd_data present in the same cycle.
- Response routing:
  - rsp_valid[i] = rd_valid & head.vld & (head.idx==i), combinational from rd_valid.
  - Latency: request accepted at edge k produces rsp_valid in the cycle after edge k+RD_LAT-1, i.e. RD_LAT cycles after the accept cycle.
  - No response backpressure; requesters must sink data in that cycle.
- Errors: err_sticky sets on the next edge in either case:
  - Orphan: rd_valid=1 with head.vld=0. rsp_valid stays 0 and the data is dropped.
  - Missing: head.vld=1 with rd_valid=0. The tag is discarded and no rsp_valid is generated.
- err_clr: if err_clr and a new error occur on the same edge, the set wins.
- Reset mid-operation: the tag pipe clears immediately (async). Data for reads issued before reset that returns after reset is an orphan: it raises err_sticky and is not delivered.
- Single requester (NREQ=1 or only one valid): that requester is granted every cycle while valid.
- rr_ptr wrap: after granting index NREQ-1, the search starts at 0.

Test Plan:
- Single read: requester 0 issues addr 0x05, RD_LAT=2, RAM row 5 preloaded with pattern P. Required: req_ready[0]=1 in the same cycle; rsp_valid=2'b01 exactly 2 cycles later with rsp_data=P; err_sticky stays 0.
- Contention: both requesters hold valid for 6 cycles, r0 addr 0x00.., r1 addr 0x10... Required: grants alternate r0,r1,r0,r1,r0,r1; 6 rd_read pulses back-to-back; responses return in the same interleaved order with matching rows.
- Fairness: NREQ=4, only r2 and r3 valid for 5 cycles, after r3 was the last grant. Required: grant order r2,r3,r2,r3,r2; r0 and r1 are never granted.
- Orphan: force rd_valid=1 for 1 cycle with no read outstanding. Required: rsp_valid=0 and err_sticky=1 on the next edge. Pulse err_clr with no new error: err_sticky returns to 0.
- Reset mid-flight: accept 2 reads, then assert areset for 1 cycle before any data returns while the RAM still returns both. Required: all outputs 0 during reset; no rsp_valid after reset; err_sticky=1; the first post-reset grant goes to r0.
- Random soak: 500 random requests from 2 requesters, RAM model preloaded as in credit_return tests (row r = 0x0A00+16r..). Required: every response matches its scoreboard entry for the issuing requester; response count equals request count; err_sticky=0.
